stepper_pulse_gen: RTL

STEPPER_PULSE_GEN -- requirements
Module: stepper_pulse_gen

---
 rtl/stepper_pkg.sv | 24 ++
 rtl/stepper_cycle_counter.sv | 36 +++
 rtl/stepper_pulse_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper pulse generator.
// Holds the FSM state encoding, default timing constants and the
// period clamp helper used when a step is launched.
package stepper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DIR_SETUP = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } step_state_e;

    localparam int   DEFAULT_PULSE_WIDTH = 4;
    localparam int   DEFAULT_DIR_SETUP   = 8;
    localparam logic DIR_FORWARD         = 1'b1;

    // A period shorter than the high time plus one low clock cannot be
    // produced, so requested periods are raised to that floor.
    function automatic logic [31:0] clampPeriod(input logic [31:0] speed,
                                                input logic [31:0] minPeriod);
        return (speed < minPeriod) ? minPeriod : speed;
    endfunction

endpackage

// File: rtl/stepper_cycle_counter.sv
// Loadable 32-bit down-counter that times every FSM phase.
// A load sets the count; otherwise it decrements and parks at zero.
// zero_o flags the last clock of the phase that was loaded.
module stepper_cycle_counter (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        load_i,
    input  logic [31:0] value_i,
    output logic        zero_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Load has priority over counting; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 32'd0);

endmodule

// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator for a stepper motor driver.
// Inputs are sampled only in IDLE and at the end of each LOW phase, so a
// pulse in flight is never altered. Every output comes from a flop.
// Optional feature: define STEPPER_POSITION_EN to build the signed
// position counter; otherwise position is tied to zero.
module stepper_pulse_gen
    import stepper_pkg::*;
#(
    parameter int PULSE_WIDTH = DEFAULT_PULSE_WIDTH,
    parameter int DIR_SETUP   = DEFAULT_DIR_SETUP
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] step_dir,
    input  logic [31:0] step_speed,
    output logic        step_out,
    output logic        dir_out,
    output logic        enable_out,
    output logic        busy,
    output logic [31:0] position
);

    localparam logic [31:0] PW_WORD    = 32'(PULSE_WIDTH);
    localparam logic [31:0] MIN_PERIOD = 32'(PULSE_WIDTH + 1);
    localparam logic [31:0] HIGH_LOAD  = 32'(PULSE_WIDTH - 1);
    localparam logic [31:0] SETUP_LOAD = 32'(DIR_SETUP - 1);

    step_state_e state_q, state_d;
    logic        stepOut_q, stepOut_d;
    logic        dirOut_q, dirOut_d;
    logic        enable_q, enable_d;
    logic        busy_q, busy_d;
    logic [31:0] effPeriod_q, effPeriod_d;

    logic        cntLoad;
    logic [31:0] cntValue;
    logic        cntZero;
    logic        sampleNow;
    logic        enterHigh;
    logic        unusedDirBits;

    // Only bit 0 of the direction word carries meaning.
    assign unusedDirBits = ^step_dir[31:1];

    stepper_cycle_counter u_counter (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .load_i     (cntLoad),
        .value_i    (cntValue),
        .zero_o     (cntZero)
    );

    // Next-state logic: phase timing from the counter, input sampling in
    // IDLE and at the last LOW clock, and a common HIGH-entry path.
    always_comb begin
        state_d     = state_q;
        stepOut_d   = stepOut_q;
        dirOut_d    = dirOut_q;
        effPeriod_d = effPeriod_q;
        cntLoad     = 1'b0;
        cntValue    = 32'd0;
        enterHigh   = 1'b0;
        sampleNow   = (state_q == ST_IDLE) || ((state_q == ST_LOW) && cntZero);

        case (state_q)
            ST_DIR_SETUP: begin
                if (cntZero) begin
                    enterHigh = 1'b1;
                end
            end
            ST_HIGH: begin
                if (cntZero) begin
                    state_d   = ST_LOW;
                    stepOut_d = 1'b0;
                    cntLoad   = 1'b1;
                    cntValue  = effPeriod_q - PW_WORD - 32'd1;
                end
            end
            default: begin
            end
        endcase

        if (sampleNow) begin
            stepOut_d = 1'b0;
            if (step_speed == 32'd0) begin
                state_d = ST_IDLE;
            end else begin
                // The period is captured here so speed changes made while
                // the direction settles do not affect the coming step.
                effPeriod_d = clampPeriod(step_speed, MIN_PERIOD);
                if (step_dir[0] != dirOut_q) begin
                    state_d  = ST_DIR_SETUP;
                    dirOut_d = step_dir[0];
                    cntLoad  = 1'b1;
                    cntValue = SETUP_LOAD;
                end else begin
                    enterHigh = 1'b1;
                end
            end
        end

        if (enterHigh) begin
            state_d   = ST_HIGH;
            stepOut_d = 1'b1;
            cntLoad   = 1'b1;
            cntValue  = HIGH_LOAD;
        end

        enable_d = (state_d != ST_IDLE);
        busy_d   = (state_d == ST_DIR_SETUP) || (state_d == ST_HIGH);
    end

    // State and output registers; reset drops every pin immediately.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q     <= ST_IDLE;
            stepOut_q   <= 1'b0;
            dirOut_q    <= 1'b0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            effPeriod_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            stepOut_q   <= stepOut_d;
            dirOut_q    <= dirOut_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            effPeriod_q <= effPeriod_d;
        end
    end

`ifdef STEPPER_POSITION_EN
    logic [31:0] position_q, position_d;

    // Each step moves the count by one in the current direction,
    // wrapping naturally in two's complement.
    always_comb begin
        position_d = position_q;
        if (enterHigh) begin
            position_d = (dirOut_q == DIR_FORWARD) ? position_q + 32'd1
                                                   : position_q - 32'd1;
        end
    end

    // Position register, updated together with the rising step edge.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            position_q <= 32'd0;
        end else begin
            position_q <= position_d;
        end
    end

    assign position = position_q;
`else
    assign position = 32'd0;
`endif

    assign step_out   = stepOut_q;
    assign dir_out    = dirOut_q;
    assign enable_out = enable_q;
    assign busy       = busy_q;

endmodule
